// File: rtl/cache_line_mem.sv
// Memory-side responder for cache line refill/write-back with fixed programmable latency.
// Optional rd_cnt/wr_cnt statistics counters are compiled in with CACHE_LINE_MEM_STATS_EN.
module cache_line_mem #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready
`ifdef CACHE_LINE_MEM_STATS_EN
  ,
  output logic [15:0]  rd_cnt,
  output logic [15:0]  wr_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [7:0] CNT_INIT = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

  state_t            state;
  logic [7:0]        cnt;
  logic [127:0]      line_mem [2**ADDR_W];
  logic [ADDR_W-1:0] line_idx;
  logic              req;
  logic              do_write;
  logic              do_read;
  logic              unused_addr_bits;

  assign line_idx         = mem_addr[ADDR_W-1:0];
  assign unused_addr_bits = ^mem_addr[27:ADDR_W];
  assign req              = mem_read | mem_write;
  // Write wins over a simultaneous read; a request dropped in RESP does neither.
  assign do_write         = (state == RESP) && mem_write;
  assign do_read          = (state == RESP) && mem_read && !mem_write;

  // Control: mem_ready is registered and high exactly while the FSM sits in RESP.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      mem_ready <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (LATENCY == 1) begin
              state     <= RESP;
              mem_ready <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
          end else if (cnt == 8'd0) begin
            state     <= RESP;
            mem_ready <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Data: the line array is never reset; address and data are used only in RESP.
  always_ff @(posedge clk) begin
    if (do_write) line_mem[line_idx] <= mem_wdata;
  end

  assign mem_rdata = do_read ? line_mem[line_idx] : 128'd0;

`ifdef CACHE_LINE_MEM_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      rd_cnt <= 16'd0;
      wr_cnt <= 16'd0;
    end else begin
      if (do_read)  rd_cnt <= sat_inc(rd_cnt);
      if (do_write) wr_cnt <= sat_inc(wr_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_cache_line_mem.sv
// Scoreboard bench for cache_line_mem: a LATENCY=4 and a LATENCY=1 instance, directed vectors.
// Stats counters are checked when CACHE_LINE_MEM_STATS_EN is defined.
module tb_cache_line_mem;

  typedef struct {
    int           cyc;
    logic [127:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         proc_reset = 1'b1;
  logic         rd4 = 1'b0, wr4 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic [27:0]  addr4 = '0, addr1 = '0;
  logic [127:0] wd4 = '0, wd1 = '0;
  logic [127:0] rdata4, rdata1;
  logic         ready4, ready1;
`ifdef CACHE_LINE_MEM_STATS_EN
  logic [15:0]  rd_cnt4, wr_cnt4, rd_cnt1, wr_cnt1;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, e1;

  localparam logic [127:0] L1 = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
  localparam logic [127:0] L2 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
  localparam logic [127:0] LA = 128'hAAAA_0000_AAAA_1111_AAAA_2222_AAAA_3333;
  localparam logic [127:0] LB = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;
  localparam logic [127:0] LC = 128'hCCCC_0001_CCCC_0002_CCCC_0003_CCCC_0004;
  localparam logic [127:0] LD = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [127:0] LE = 128'hEEEE_EEEE_0000_0000_EEEE_EEEE_0000_0000;
  localparam logic [127:0] LF = 128'h0F0F_0F0F_F0F0_F0F0_5555_AAAA_3C3C_C3C3;

  cache_line_mem #(.ADDR_W(10), .LATENCY(4)) dut4 (
    .clk(clk), .proc_reset(proc_reset), .mem_read(rd4), .mem_write(wr4),
    .mem_addr(addr4), .mem_wdata(wd4), .mem_rdata(rdata4), .mem_ready(ready4)
`ifdef CACHE_LINE_MEM_STATS_EN
    , .rd_cnt(rd_cnt4), .wr_cnt(wr_cnt4)
`endif
  );

  cache_line_mem #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk(clk), .proc_reset(proc_reset), .mem_read(rd1), .mem_write(wr1),
    .mem_addr(addr1), .mem_wdata(wd1), .mem_rdata(rdata1), .mem_ready(ready1)
`ifdef CACHE_LINE_MEM_STATS_EN
    , .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop an expectation on every mem_ready, require zero data otherwise.
  always @(negedge clk) begin
    if (ready4 === 1'b1) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL ready4_unexpected: got ready=1 expected no response (cycle %0d)", cyc);
      end else begin
        e4 = q4.pop_front();
        chk("ready4_cycle", 128'(cyc), 128'(e4.cyc));
        chk("rdata4", rdata4, e4.data);
      end
    end else begin
      chk("rdata4_idle", rdata4, 128'd0);
    end
  end

  always @(negedge clk) begin
    if (ready1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL ready1_unexpected: got ready=1 expected no response (cycle %0d)", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("ready1_cycle", 128'(cyc), 128'(e1.cyc));
        chk("rdata1", rdata1, e1.data);
      end
    end else begin
      chk("rdata1_idle", rdata1, 128'd0);
    end
  end

  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [27:0] a, input logic [127:0] d);
    if (sel) begin rd1 = rd; wr1 = wr; addr1 = a; wd1 = d; end
    else     begin rd4 = rd; wr4 = wr; addr4 = a; wd4 = d; end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Issue a request held through RESP; returns in the cycle after RESP with inputs cleared.
  task automatic req(input bit sel, input bit rd, input bit wr, input logic [27:0] a,
                     input logic [127:0] d, input logic [127:0] exp,
                     input bit stale, input bit drop);
    int   lat;
    exp_t e;
    lat = sel ? 1 : 4;
    drive(sel, rd, wr, stale ? 28'h0 : a, d);
    e.cyc  = cyc + lat;
    e.data = exp;
    if (sel) q1.push_back(e); else q4.push_back(e);
    for (int i = 0; i < lat; i++) begin
      step(1);
      if (stale && i == 0) drive(sel, rd, wr, a, d);
      if (drop && i == lat - 1) drive(sel, 1'b0, 1'b0, a, d);
    end
    step(1);
    drive(sel, 1'b0, 1'b0, 28'h0, 128'd0);
  endtask

  // Request dropped while the LATENCY=4 instance is in WAIT.
  task automatic abort4(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d);
    drive(1'b0, rd, wr, a, d);
    step(2);
    drive(1'b0, 1'b0, 1'b0, 28'h0, 128'd0);
    step(2);
  endtask

  initial begin
    #2;
    chk("reset_ready4", 128'(ready4), 128'd0);
    chk("reset_ready1", 128'(ready1), 128'd0);
    chk("reset_rdata4", rdata4, 128'd0);
`ifdef CACHE_LINE_MEM_STATS_EN
    chk("reset_rd_cnt", 128'(rd_cnt4), 128'd0);
    chk("reset_wr_cnt", 128'(wr_cnt4), 128'd0);
`endif
    step(3);
    proc_reset = 1'b0;
    step(1);

    // Write then read, stale first-cycle address
    req(0, 0, 1, 28'h5, L1, 128'd0, 0, 0);
    step(2);
    req(0, 1, 0, 28'h5, '0, L1, 0, 0);
    step(1);
    req(0, 1, 0, 28'h5, '0, L1, 1, 0);
    step(1);

    // Back-to-back write-back then allocate of the same line
    req(0, 0, 1, 28'h9, L2, 128'd0, 0, 0);
    req(0, 1, 0, 28'h9, '0, L2, 0, 0);
    step(1);
    req(0, 1, 0, 28'h9, '0, L2, 0, 0);
    step(1);

    // Abort in WAIT leaves old contents
    req(0, 0, 1, 28'h7, LA, 128'd0, 0, 0);
    step(1);
    abort4(0, 1, 28'h7, LB);
    abort4(1, 0, 28'h7, '0);
    req(0, 1, 0, 28'h7, '0, LA, 0, 0);
    step(1);

    // Reset during WAIT of a write discards it
    drive(0, 0, 1, 28'h7, LC);
    step(2);
    proc_reset = 1'b1;
    drive(0, 0, 0, 28'h0, 128'd0);
    #1;
    chk("midreset_ready4", 128'(ready4), 128'd0);
    step(1);
    proc_reset = 1'b0;
    step(1);
    req(0, 1, 0, 28'h7, '0, LA, 0, 0);
    step(1);

    // Simultaneous read+write: write wins, no data
    req(0, 1, 1, 28'hB, LD, 128'd0, 0, 0);
    req(0, 1, 0, 28'hB, '0, LD, 0, 0);
    step(1);

    // Write dropped in RESP: pulse but no write
    req(0, 0, 1, 28'h5, LE, 128'd0, 0, 1);
    step(1);
    req(0, 1, 0, 28'h5, '0, L1, 0, 0);
    step(1);

    // LATENCY=1 and address aliasing
    req(1, 0, 1, 28'h400, LF, 128'd0, 0, 0);
    req(1, 1, 0, 28'h0, '0, LF, 0, 0);
    step(1);
    req(1, 1, 0, 28'h400, '0, LF, 0, 0);
    step(2);

`ifdef CACHE_LINE_MEM_STATS_EN
    proc_reset = 1'b1;
    step(1);
    proc_reset = 1'b0;
    step(1);
    req(0, 0, 1, 28'h20, LA, 128'd0, 0, 0);
    req(0, 0, 1, 28'h21, LB, 128'd0, 0, 0);
    req(0, 1, 0, 28'h20, '0, LA, 0, 0);
    req(0, 1, 0, 28'h21, '0, LB, 0, 0);
    req(0, 1, 0, 28'h20, '0, LA, 0, 0);
    abort4(1, 0, 28'h21, '0);
    chk("stats_rd_cnt", 128'(rd_cnt4), 128'd3);
    chk("stats_wr_cnt", 128'(wr_cnt4), 128'd2);
    proc_reset = 1'b1;
    #1;
    chk("stats_rd_cnt_reset", 128'(rd_cnt4), 128'd0);
    chk("stats_wr_cnt_reset", 128'(wr_cnt4), 128'd0);
    step(1);
    proc_reset = 1'b0;
    step(2);
`endif

    chk("pending4_left", 128'(q4.size()), 128'd0);
    chk("pending1_left", 128'(q1.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
